// File: rtl/elevator_ctrl_pkg.sv
// elevator_ctrl_pkg: shared types and codes for the elevator controller.
//   - state_e       : controller FSM states
//   - ENG_*         : engine command codes
//   - DOOR_*        : door command codes
//   - SD_*          : door-limit sensor codes
//   - *_DEF         : default floor count and door dwell time
package elevator_ctrl_pkg;

  localparam int BUTTONS_WIDTH_DEF = 8;
  localparam int DOOR_WAIT_DEF     = 10;
  localparam int LVL_W             = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_UP   = 3'd1,
    MOVE_DOWN = 3'd2,
    STOPPING  = 3'd3,
    OPENING   = 3'd4,
    DWELL     = 3'd5,
    CLOSING   = 3'd6
  } state_e;

  localparam logic [1:0] ENG_STOP   = 2'b00;
  localparam logic [1:0] ENG_UP     = 2'b01;
  localparam logic [1:0] ENG_DOWN   = 2'b10;

  localparam logic [1:0] DOOR_HOLD  = 2'b00;
  localparam logic [1:0] DOOR_OPEN  = 2'b01;
  localparam logic [1:0] DOOR_CLOSE = 2'b10;

  localparam logic [1:0] SD_TRANSIT = 2'b00;
  localparam logic [1:0] SD_OPEN    = 2'b01;
  localparam logic [1:0] SD_CLOSED  = 2'b10;

endpackage

// File: rtl/elevator_req_reg.sv
// elevator_req_reg: per-floor call latch.
//   clk, rst      : clock, asynchronous active-high reset
//   set_i         : OR of all call buttons this cycle (one bit per floor)
//   clr_i         : floors served this cycle
//   level_i       : current floor
//   pending_o     : latched calls
//   any_above_o   : a latched call lies above level_i
//   any_below_o   : a latched call lies below level_i
module elevator_req_reg
  import elevator_ctrl_pkg::*;
#(
  parameter int BUTTONS_WIDTH = BUTTONS_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BUTTONS_WIDTH-1:0] set_i,
  input  logic [BUTTONS_WIDTH-1:0] clr_i,
  input  logic [LVL_W-1:0]         level_i,
  output logic [BUTTONS_WIDTH-1:0] pending_o,
  output logic                     any_above_o,
  output logic                     any_below_o
);

  logic [BUTTONS_WIDTH-1:0] pending_q;
  logic [BUTTONS_WIDTH-1:0] pending_d;

  // A press landing in the same cycle as a clear survives.
  assign pending_d = (pending_q & ~clr_i) | set_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_comb begin
    any_above_o = 1'b0;
    any_below_o = 1'b0;
    for (int f = 0; f < BUTTONS_WIDTH; f++) begin
      if (pending_q[f] && (f > int'(level_i))) any_above_o = 1'b1;
      if (pending_q[f] && (f < int'(level_i))) any_below_o = 1'b1;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/elevator_ctrl.sv
// elevator_ctrl: single-car SCAN elevator controller.
//   clk, reset                 : clock, asynchronous active-high reset
//   open_btn, close_btn        : cabin door requests (level)
//   overload                   : cabin overweight, blocks door closing
//   sensor_up, sensor_down     : one-cycle floor-passage pulses
//   sensor_inside              : door-gap obstruction
//   sensor_door                : door limit (00 transit, 01 open, 10 closed)
//   btn_in/btn_up_out/btn_down_out : call buttons, one bit per floor
//   engine, door               : registered actuator commands
//   direction, level_display   : registered scan direction and floor
//   dbg_state                  : current FSM state
module elevator_ctrl
  import elevator_ctrl_pkg::*;
#(
  parameter int BUTTONS_WIDTH = BUTTONS_WIDTH_DEF,
  parameter int DOOR_WAIT     = DOOR_WAIT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     open_btn,
  input  logic                     close_btn,
  input  logic                     overload,
  input  logic                     sensor_up,
  input  logic                     sensor_down,
  input  logic                     sensor_inside,
  input  logic [1:0]               sensor_door,
  input  logic [BUTTONS_WIDTH-1:0] btn_in,
  input  logic [BUTTONS_WIDTH-1:0] btn_up_out,
  input  logic [BUTTONS_WIDTH-1:0] btn_down_out,
  output logic [1:0]               engine,
  output logic [1:0]               door,
  output logic                     direction,
  output logic [LVL_W-1:0]         level_display,
  output state_e                   dbg_state
);

  localparam int               TMR_W    = $clog2(DOOR_WAIT + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DOOR_WAIT);
  localparam logic [LVL_W-1:0] TOP_LVL  = LVL_W'(BUTTONS_WIDTH - 1);

  state_e                   state_q, state_d;
  logic [LVL_W-1:0]         level_q, level_d;
  logic                     dir_q, dir_d;
  logic [TMR_W-1:0]         timer_q, timer_d, timer_dec;
  logic [1:0]               engine_q, engine_d;
  logic [1:0]               door_q, door_d;

  logic [BUTTONS_WIDTH-1:0] set_req, clr_vec, pending, req_now;
  logic                     any_above, any_below, at_cur, clr_cur;
  logic [LVL_W-1:0]         lvl_up, lvl_dn;

  assign set_req = btn_in | btn_up_out | btn_down_out;
  // Arrival check also sees a press made on the very cycle of arrival.
  assign req_now = pending | set_req;
  assign at_cur  = pending[level_q];
  assign lvl_up  = level_q + LVL_W'(1);
  assign lvl_dn  = level_q - LVL_W'(1);

  always_comb begin
    clr_vec          = '0;
    clr_vec[level_q] = clr_cur;
  end

  elevator_req_reg #(
    .BUTTONS_WIDTH(BUTTONS_WIDTH)
  ) u_req (
    .clk        (clk),
    .rst        (reset),
    .set_i      (set_req),
    .clr_i      (clr_vec),
    .level_i    (level_q),
    .pending_o  (pending),
    .any_above_o(any_above),
    .any_below_o(any_below)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      level_q  <= '0;
      dir_q    <= 1'b1;
      timer_q  <= '0;
      engine_q <= ENG_STOP;
      door_q   <= DOOR_HOLD;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      dir_q    <= dir_d;
      timer_q  <= timer_d;
      engine_q <= engine_d;
      door_q   <= door_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    dir_d     = dir_q;
    timer_d   = timer_q;
    clr_cur   = 1'b0;
    timer_dec = (timer_q == '0) ? '0 : timer_q - TMR_W'(1);
    case (state_q)
      IDLE: begin
        if (at_cur) begin
          state_d = OPENING;
          clr_cur = 1'b1;
        end else if (dir_q && any_above) begin
          state_d = MOVE_UP;
        end else if (!dir_q && any_below) begin
          state_d = MOVE_DOWN;
        end else if (any_above) begin
          state_d = MOVE_UP;
          dir_d   = 1'b1;
        end else if (any_below) begin
          state_d = MOVE_DOWN;
          dir_d   = 1'b0;
        end
      end
      MOVE_UP: begin
        if (sensor_up && (level_q != TOP_LVL)) begin
          level_d = lvl_up;
          if (req_now[lvl_up]) state_d = STOPPING;
        end
      end
      MOVE_DOWN: begin
        if (sensor_down && (level_q != '0)) begin
          level_d = lvl_dn;
          if (req_now[lvl_dn]) state_d = STOPPING;
        end
      end
      STOPPING: begin
        clr_cur = 1'b1;
        state_d = OPENING;
      end
      OPENING: begin
        // Serves a call for this floor made while the door is opening.
        clr_cur = 1'b1;
        if (sensor_door == SD_OPEN) begin
          state_d = DWELL;
          timer_d = TMR_LOAD;
        end
      end
      DWELL: begin
        if (close_btn && !overload) begin
          state_d = CLOSING;
        end else if (open_btn || at_cur) begin
          timer_d = TMR_LOAD;
          clr_cur = 1'b1;
        end else begin
          // Timer parks at zero while overloaded; closing resumes once it drops.
          timer_d = timer_dec;
          if ((timer_dec == '0) && !overload) state_d = CLOSING;
        end
      end
      CLOSING: begin
        if (sensor_inside || open_btn || overload || at_cur) begin
          state_d = OPENING;
        end else if (sensor_door == SD_CLOSED) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Engine runs only while the car stays in a move state and the door is shut,
  // so it drops to stop on the arrival cycle and starts a cycle after entry.
  always_comb begin
    engine_d = ENG_STOP;
    if (sensor_door == SD_CLOSED) begin
      if ((state_q == MOVE_UP) && (state_d == MOVE_UP)) begin
        engine_d = ENG_UP;
      end else if ((state_q == MOVE_DOWN) && (state_d == MOVE_DOWN)) begin
        engine_d = ENG_DOWN;
      end
    end
  end

  always_comb begin
    case (state_d)
      OPENING: door_d = DOOR_OPEN;
      CLOSING: door_d = DOOR_CLOSE;
      default: door_d = DOOR_HOLD;
    endcase
  end

  assign engine        = engine_q;
  assign door          = door_q;
  assign direction     = dir_q;
  assign level_display = level_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
module tb_elevator_ctrl;
  import elevator_ctrl_pkg::*;

  localparam int BW = 8;
  localparam int DW = 10;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          open_btn, close_btn, overload, sensor_inside;
  logic          sensor_up = 1'b0, sensor_down = 1'b0;
  logic [1:0]    sensor_door = SD_CLOSED;
  logic [BW-1:0] btn_in, btn_up_out, btn_down_out;
  logic [1:0]    engine, door;
  logic          direction;
  logic [2:0]    level_display;
  state_e        dbg_state;

  always #5 clk = ~clk;

  elevator_ctrl #(.BUTTONS_WIDTH(BW), .DOOR_WAIT(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .open_btn     (open_btn),
    .close_btn    (close_btn),
    .overload     (overload),
    .sensor_up    (sensor_up),
    .sensor_down  (sensor_down),
    .sensor_inside(sensor_inside),
    .sensor_door  (sensor_door),
    .btn_in       (btn_in),
    .btn_up_out   (btn_up_out),
    .btn_down_out (btn_down_out),
    .engine       (engine),
    .door         (door),
    .direction    (direction),
    .level_display(level_display),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- plant model + level scoreboard ----------------
  logic [2:0] exp_q[$];
  logic [2:0] exp_lvl   = 3'd0;
  logic [2:0] exp_pop;
  logic [1:0] last_door = DOOR_HOLD;
  logic       pulse_prev = 1'b0;
  int eng_cnt = 0, door_cnt = 0;
  int lvl_bad = 0, lvl_steps = 0, safety_bad = 0;
  int up_cycles = 0, dn_cycles = 0, close_cycles = 0;

  always @(negedge clk) begin
    sensor_up   = 1'b0;
    sensor_down = 1'b0;
    if (reset) begin
      eng_cnt     = 0;
      door_cnt    = 0;
      last_door   = DOOR_HOLD;
      sensor_door = SD_CLOSED;
      pulse_prev  = 1'b0;
      exp_lvl     = 3'd0;
      exp_q.delete();
    end else begin
      if (pulse_prev) begin
        pulse_prev = 1'b0;
        if (exp_q.size() > 0) begin
          exp_pop = exp_q.pop_front();
          lvl_steps++;
          if (level_display !== exp_pop) lvl_bad++;
        end
      end
      if (engine == ENG_UP)     up_cycles++;
      if (engine == ENG_DOWN)   dn_cycles++;
      if (door == DOOR_CLOSE)   close_cycles++;
      if (engine != ENG_STOP && (sensor_door != SD_CLOSED || door != DOOR_HOLD)) safety_bad++;
      if (engine == 2'b11 || door == 2'b11) safety_bad++;
      // motor: one floor every 60 cycles of engine drive
      if (engine == ENG_STOP) begin
        eng_cnt = 0;
      end else begin
        eng_cnt++;
        if (eng_cnt == 60) begin
          eng_cnt = 0;
          if (engine == ENG_UP) begin
            sensor_up = 1'b1;
            exp_lvl   = (exp_lvl == 3'd7) ? 3'd7 : exp_lvl + 3'd1;
          end else begin
            sensor_down = 1'b1;
            exp_lvl     = (exp_lvl == 3'd0) ? 3'd0 : exp_lvl - 3'd1;
          end
          exp_q.push_back(exp_lvl);
          pulse_prev = 1'b1;
        end
      end
      // door: reaches the commanded limit 5 cycles after the command
      if (door != last_door) door_cnt = 0;
      last_door = door;
      if (door == DOOR_OPEN && sensor_door != SD_OPEN) begin
        door_cnt++;
        sensor_door = (door_cnt >= 5) ? SD_OPEN : SD_TRANSIT;
      end else if (door == DOOR_CLOSE && sensor_door != SD_CLOSED) begin
        door_cnt++;
        sensor_door = (door_cnt >= 5) ? SD_CLOSED : SD_TRANSIT;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press(input logic [BW-1:0] bi, input logic [BW-1:0] bu, input logic [BW-1:0] bd);
    btn_in = bi; btn_up_out = bu; btn_down_out = bd;
    @(negedge clk);
    btn_in = '0; btn_up_out = '0; btn_down_out = '0;
  endtask

  task automatic wait_door(input logic [1:0] want, input int bound, input string name);
    int k = 0;
    while (door !== want && k < bound) begin @(negedge clk); k++; end
    check(name, door, want);
  endtask

  task automatic wait_state(input state_e want, input int bound, input string name);
    int k = 0;
    while (dbg_state !== want && k < bound) begin @(negedge clk); k++; end
    check(name, dbg_state, want);
  endtask

  task automatic wait_level(input logic [2:0] want, input int bound, input string name);
    int k = 0;
    while (level_display !== want && k < bound) begin @(negedge clk); k++; end
    check(name, level_display, want);
  endtask

  task automatic count_hold(output int n);
    n = 0;
    while (door == DOOR_HOLD && n < 200) begin @(negedge clk); n++; end
  endtask

  // called right after door went to OPEN
  task automatic measure_dwell(output int n);
    int k = 0;
    while (door == DOOR_OPEN && k < 50) begin @(negedge clk); k++; end
    count_hold(n);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [BW-1:0] bi, bu, bd;
    logic [2:0]    exp_lvl;
    logic          exp_dir;
    logic [1:0]    exp_eng;
  } vec_t;
  vec_t vecs[9];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, up0, dn0, c0, st0;
    vecs[0] = '{8'h20, 8'h00, 8'h00, 3'd5, 1'b0, ENG_DOWN}; // 7 -> 5
    vecs[1] = '{8'h00, 8'h00, 8'h08, 3'd3, 1'b0, ENG_DOWN}; // 5 -> 3
    vecs[2] = '{8'h00, 8'h40, 8'h00, 3'd6, 1'b1, ENG_UP};   // reverse up
    vecs[3] = '{8'h01, 8'h00, 8'h00, 3'd0, 1'b0, ENG_DOWN}; // 6 -> 0
    vecs[4] = '{8'h00, 8'h04, 8'h00, 3'd2, 1'b1, ENG_UP};   // 0 -> 2
    vecs[5] = '{8'h00, 8'h00, 8'h01, 3'd0, 1'b0, ENG_DOWN}; // reverse down
    vecs[6] = '{8'h08, 8'h00, 8'h20, 3'd3, 1'b1, ENG_UP};   // two calls: nearer first
    vecs[7] = '{8'h00, 8'h00, 8'h00, 3'd5, 1'b1, ENG_UP};   // leftover call served
    vecs[8] = '{8'h01, 8'h00, 8'h00, 3'd0, 1'b0, ENG_DOWN}; // back to 0

    reset = 1'b1; open_btn = 0; close_btn = 0; overload = 0; sensor_inside = 0;
    btn_in = '0; btn_up_out = '0; btn_down_out = '0;
    repeat (3) @(negedge clk);
    check("rst_engine", engine, ENG_STOP);
    check("rst_door", door, DOOR_HOLD);
    check("rst_dir", direction, 1);
    check("rst_level", level_display, 0);
    check("rst_state", dbg_state, IDLE);
    reset = 1'b0;
    @(negedge clk);

    // 0 -> 7 with a cabin call
    up0 = up_cycles; st0 = lvl_steps;
    press(8'h80, 8'h00, 8'h00);
    wait_door(DOOR_OPEN, 1000, "s1_open");
    check("s1_level", level_display, 7);
    check("s1_engine_stop", engine, ENG_STOP);
    check("s1_went_up", up_cycles > up0, 1);
    check("s1_dir", direction, 1);
    check("s1_steps", lvl_steps - st0, 7);
    measure_dwell(n);
    check("s1_dwell", n, DW);
    wait_state(IDLE, 50, "s1_idle");
    up0 = up_cycles; dn0 = dn_cycles;
    repeat (100) @(negedge clk);
    check("s1_no_pending", (up_cycles - up0) + (dn_cycles - dn0), 0);
    check("s1_still_idle", dbg_state, IDLE);

    // hall call at the current floor: open in place
    up0 = up_cycles; dn0 = dn_cycles;
    press(8'h00, 8'h00, 8'h80);
    wait_door(DOOR_OPEN, 10, "s2_open");
    measure_dwell(n);
    check("s2_dwell", n, DW);
    wait_state(IDLE, 50, "s2_idle");
    check("s2_no_motion", (up_cycles - up0) + (dn_cycles - dn0), 0);
    check("s2_level", level_display, 7);

    // table of trips
    for (int i = 0; i < 9; i++) begin
      up0 = up_cycles; dn0 = dn_cycles;
      press(vecs[i].bi, vecs[i].bu, vecs[i].bd);
      wait_door(DOOR_OPEN, 1000, $sformatf("tbl%0d_open", i));
      check($sformatf("tbl%0d_level", i), level_display, vecs[i].exp_lvl);
      check($sformatf("tbl%0d_dir", i), direction, vecs[i].exp_dir);
      check($sformatf("tbl%0d_eng_stop", i), engine, ENG_STOP);
      if (vecs[i].exp_eng == ENG_UP) begin
        check($sformatf("tbl%0d_went_up", i), up_cycles > up0, 1);
        check($sformatf("tbl%0d_no_down", i), dn_cycles - dn0, 0);
      end else begin
        check($sformatf("tbl%0d_went_down", i), dn_cycles > dn0, 1);
        check($sformatf("tbl%0d_no_up", i), up_cycles - up0, 0);
      end
      wait_door(DOOR_CLOSE, 100, $sformatf("tbl%0d_close", i));
      wait_state(IDLE, 50, $sformatf("tbl%0d_idle", i));
    end

    // SCAN: call ahead and behind while moving up from 0
    press(8'h80, 8'h00, 8'h00);
    wait_level(3'd2, 300, "s5_at2");
    dn0 = dn_cycles;
    press(8'h02, 8'h10, 8'h00);
    wait_door(DOOR_OPEN, 400, "s5_open4");
    check("s5_level4", level_display, 4);
    check("s5_dir4", direction, 1);
    wait_door(DOOR_CLOSE, 100, "s5_close4");
    wait_door(DOOR_OPEN, 600, "s5_open7");
    check("s5_level7", level_display, 7);
    check("s5_no_reverse", dn_cycles - dn0, 0);
    wait_door(DOOR_CLOSE, 100, "s5_close7");
    wait_door(DOOR_OPEN, 800, "s5_open1");
    check("s5_level1", level_display, 1);
    check("s5_dir1", direction, 0);
    wait_door(DOOR_CLOSE, 100, "s5_close1");
    wait_state(IDLE, 50, "s5_idle");

    // overload holds the door, then obstruction reopens it
    overload = 1'b1;
    press(8'h02, 8'h00, 8'h00);
    wait_door(DOOR_OPEN, 10, "s6_open");
    wait_door(DOOR_HOLD, 20, "s6_dwell_start");
    c0 = close_cycles;
    repeat (40) @(negedge clk);
    check("s6_no_close", close_cycles - c0, 0);
    check("s6_in_dwell", dbg_state, DWELL);
    overload = 1'b0;
    @(negedge clk);
    check("s6_close_on_drop", door, DOOR_CLOSE);
    sensor_inside = 1'b1;
    @(negedge clk);
    sensor_inside = 1'b0;
    check("s6_reopen_inside", door, DOOR_OPEN);

    // close button cuts the dwell, open button reopens while closing
    wait_door(DOOR_HOLD, 20, "s7_dwell");
    repeat (2) @(negedge clk);
    close_btn = 1'b1;
    @(negedge clk);
    close_btn = 1'b0;
    check("s7_close_btn", door, DOOR_CLOSE);
    open_btn = 1'b1;
    @(negedge clk);
    open_btn = 1'b0;
    check("s7_reopen_btn", door, DOOR_OPEN);

    // open button in dwell reloads the full wait
    wait_door(DOOR_HOLD, 20, "s8_dwell");
    repeat (5) @(negedge clk);
    open_btn = 1'b1;
    @(negedge clk);
    open_btn = 1'b0;
    count_hold(n);
    check("s8_reload_dwell", n, DW);
    wait_state(IDLE, 50, "s8_idle");

    // asynchronous reset mid-travel
    press(8'h40, 8'h00, 8'h00);
    wait_level(3'd3, 300, "s9_at3");
    check("s9_moving", engine, ENG_UP);
    #2 reset = 1'b1;
    #1;
    check("s9_rst_engine", engine, ENG_STOP);
    check("s9_rst_level", level_display, 0);
    check("s9_rst_door", door, DOOR_HOLD);
    check("s9_rst_dir", direction, 1);
    check("s9_rst_state", dbg_state, IDLE);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    up0 = up_cycles; dn0 = dn_cycles;
    repeat (150) @(negedge clk);
    check("s9_requests_cleared", (up_cycles - up0) + (dn_cycles - dn0), 0);
    check("s9_level_after", level_display, 0);

    check("level_scoreboard", lvl_bad, 0);
    check("engine_door_safety", safety_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
